// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (C)
// and loader/DMA (D) ports, with bounded grant locking and 1-cycle read responses.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic          c_lock,
    input  logic [AW-1:0] c_adr,
    input  logic [DW-1:0] c_wd,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rd,
    output logic          c_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_lock,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wd,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rd,
    output logic          d_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);
    localparam int            CW      = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {OWN_C = 1'b0, OWN_D = 1'b1} owner_e;

    owner_e         last_owner_q, last_owner_d;
    owner_e         resp_owner_q, resp_owner_d;
    logic           locked_q, locked_d;
    logic [CW-1:0]  lock_cnt_q, lock_cnt_d;
    logic           resp_valid_q, resp_valid_d;
    logic           resp_err_q, resp_err_d;
    logic           resp_read_q, resp_read_d;

    logic           gnt_c, gnt_d, accept, owner_req;
    logic           g_we, g_lock, aligned;
    owner_e         g_owner;
    logic [AW-1:0]  g_adr;
    logic [DW-1:0]  g_wd;

    // A locked owner keeps the grant only while it still requests and has budget left.
    always_comb begin
        gnt_c     = 1'b0;
        gnt_d     = 1'b0;
        owner_req = (last_owner_q == OWN_C) ? c_req : d_req;
        if (!reset) begin
            if (locked_q && owner_req && (lock_cnt_q < CNT_MAX)) begin
                gnt_c = (last_owner_q == OWN_C);
                gnt_d = (last_owner_q == OWN_D);
            end else if (c_req && d_req) begin
                gnt_c = (last_owner_q == OWN_D);
                gnt_d = (last_owner_q == OWN_C);
            end else begin
                gnt_c = c_req;
                gnt_d = d_req;
            end
        end
    end

    always_comb begin
        accept  = gnt_c | gnt_d;
        g_owner = gnt_d ? OWN_D : OWN_C;
        g_adr   = '0;
        g_wd    = '0;
        g_we    = 1'b0;
        g_lock  = 1'b0;
        if (gnt_c) begin
            g_adr  = c_adr;
            g_wd   = c_wd;
            g_we   = c_we;
            g_lock = c_lock;
        end else if (gnt_d) begin
            g_adr  = d_adr;
            g_wd   = d_wd;
            g_we   = d_we;
            g_lock = d_lock;
        end
        aligned = (g_adr[1:0] == 2'b00);
    end

    assign c_gnt   = gnt_c;
    assign d_gnt   = gnt_d;
    assign mem_we  = g_we & aligned;
    assign mem_adr = g_adr;
    assign mem_wd  = g_wd;

    always_comb begin
        last_owner_d = last_owner_q;
        locked_d     = locked_q;
        lock_cnt_d   = lock_cnt_q;
        resp_valid_d = accept;
        resp_owner_d = g_owner;
        resp_err_d   = accept & ~aligned;
        resp_read_d  = accept & ~g_we & aligned;
        if (accept) begin
            last_owner_d = g_owner;
            locked_d     = g_lock;
            // The count only grows while the same owner keeps holding its lock.
            if (!g_lock) begin
                lock_cnt_d = '0;
            end else if (locked_q && (g_owner == last_owner_q)) begin
                lock_cnt_d = (lock_cnt_q == CNT_MAX) ? CNT_MAX : lock_cnt_q + CNT_ONE;
            end else begin
                lock_cnt_d = CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= OWN_D;
            locked_q     <= 1'b0;
            lock_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= OWN_C;
            resp_err_q   <= 1'b0;
            resp_read_q  <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
            locked_q     <= locked_d;
            lock_cnt_q   <= lock_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
            resp_err_q   <= resp_err_d;
            resp_read_q  <= resp_read_d;
        end
    end

    assign c_rvalid = resp_valid_q & ~reset & (resp_owner_q == OWN_C);
    assign d_rvalid = resp_valid_q & ~reset & (resp_owner_q == OWN_D);
    assign c_err    = c_rvalid & resp_err_q;
    assign d_err    = d_rvalid & resp_err_q;
    assign c_rd     = (c_rvalid & resp_read_q) ? mem_rd : '0;
    assign d_rd     = (d_rvalid & resp_read_q) ? mem_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random traffic, checked
// against a behavioural arbitration/memory model and a queue of expected responses.
module tb_dmem_arbiter;
    localparam int LMAX = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0, c_lock = 1'b0;
    logic [31:0] c_adr = '0, c_wd = '0;
    logic        d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
    logic [31:0] d_adr = '0, d_wd = '0;
    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err, mem_we;
    logic [31:0] c_rd, d_rd, mem_adr, mem_wd;
    logic [31:0] mem_rd = '0;

    dmem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_adr(c_adr), .c_wd(c_wd),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rd(c_rd), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_adr(d_adr), .d_wd(d_wd),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rd(d_rd), .d_err(d_err),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rd;
        int          due;
    } resp_t;

    resp_t       expq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] mem [64];
    logic [31:0] model_mem [64];
    int          m_last, m_cnt;
    bit          m_locked;
    logic        p_req [2], p_we [2], p_lock [2];
    logic [31:0] p_adr [2], p_wd [2];
    bit          mg [2];
    logic        smp_c_gnt, smp_d_gnt, smp_mem_we, smp_c_rvalid, smp_d_rvalid, smp_c_err;
    logic [31:0] smp_mem_adr, smp_mem_wd, smp_c_rd, smp_d_rd;
    logic [31:0] radr;

    function automatic logic [31:0] initVal(int i);
        return (i == 24) ? 32'd7 : 32'(i * 3 + 1);
    endfunction

    // Data memory seen by the arbiter: synchronous read, one cycle of latency.
    always @(posedge clk) begin
        if (mem_we) mem[mem_adr[7:2]] <= mem_wd;
        mem_rd <= mem[mem_adr[7:2]];
        cyc <= cyc + 1;
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every rvalid must match the oldest outstanding accept.
    always @(negedge clk) begin
        resp_t e;
        if (c_rvalid || d_rvalid) begin
            if (c_rvalid && d_rvalid) begin
                checkOutput("dual_rvalid", 32'd1, 32'd0);
            end else if (expq.size() == 0) begin
                checkOutput("spurious_rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd0);
            end else begin
                e = expq.pop_front();
                checkOutput("rsp_port", 32'(d_rvalid), 32'(e.port));
                checkOutput("rsp_cycle", 32'(cyc), 32'(e.due));
                checkOutput("rsp_err", 32'(d_rvalid ? d_err : c_err), 32'(e.err));
                checkOutput("rsp_rd", d_rvalid ? d_rd : c_rd, e.rd);
            end
        end else if (expq.size() > 0 && expq[0].due <= cyc) begin
            e = expq.pop_front();
            checkOutput("rsp_missing", 32'd0, 32'd1);
        end
    end

    function automatic int modelGrant();
        if (m_locked && p_req[m_last] && m_cnt < LMAX) return m_last;
        if (p_req[0] && p_req[1]) return 1 - m_last;
        if (p_req[0]) return 0;
        if (p_req[1]) return 1;
        return -1;
    endfunction

    task automatic setPort(int p, logic req, logic we, logic lock, logic [31:0] adr, logic [31:0] wd);
        p_req[p] = req; p_we[p] = we; p_lock[p] = lock; p_adr[p] = adr; p_wd[p] = wd;
    endtask

    task automatic driveInputs();
        c_req = p_req[0]; c_we = p_we[0]; c_lock = p_lock[0]; c_adr = p_adr[0]; c_wd = p_wd[0];
        d_req = p_req[1]; d_we = p_we[1]; d_lock = p_lock[1]; d_adr = p_adr[1]; d_wd = p_wd[1];
    endtask

    // One clock of traffic: drive, check grant and memory side, book the response.
    task automatic applyStimulus();
        int          g;
        logic        al, ewe;
        logic [31:0] eadr, ewd;
        resp_t       e;
        driveInputs();
        @(negedge clk);
        smp_c_gnt = c_gnt; smp_d_gnt = d_gnt; smp_mem_we = mem_we;
        smp_mem_adr = mem_adr; smp_mem_wd = mem_wd;
        smp_c_rvalid = c_rvalid; smp_d_rvalid = d_rvalid; smp_c_err = c_err;
        smp_c_rd = c_rd; smp_d_rd = d_rd;
        g = modelGrant();
        eadr = (g >= 0) ? p_adr[g] : 32'd0;
        ewd  = (g >= 0) ? p_wd[g] : 32'd0;
        al   = (eadr[1:0] == 2'b00);
        ewe  = (g >= 0) && p_we[g] && al;
        checkOutput("c_gnt", 32'(c_gnt), 32'(g == 0));
        checkOutput("d_gnt", 32'(d_gnt), 32'(g == 1));
        checkOutput("mem_we", 32'(mem_we), 32'(ewe));
        checkOutput("mem_adr", mem_adr, eadr);
        checkOutput("mem_wd", mem_wd, ewd);
        mg[0] = (g == 0);
        mg[1] = (g == 1);
        if (g >= 0) begin
            e.port = g;
            e.err  = !al;
            e.rd   = (!p_we[g] && al) ? model_mem[eadr[7:2]] : 32'd0;
            e.due  = cyc + 1;
            expq.push_back(e);
            if (ewe) model_mem[eadr[7:2]] = ewd;
            if (p_lock[g]) begin
                m_cnt = (m_locked && g == m_last) ? ((m_cnt + 1 > LMAX) ? LMAX : m_cnt + 1) : 1;
                m_locked = 1'b1;
            end else begin
                m_cnt = 0;
                m_locked = 1'b0;
            end
            m_last = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        setPort(0, 1'b1, 1'b1, 1'b1, 32'd40, 32'hA5A5_0001);
        setPort(1, 1'b1, 1'b1, 1'b1, 32'd44, 32'hA5A5_0002);
        driveInputs();
        expq.delete();
        m_last = 1; m_locked = 1'b0; m_cnt = 0;
        @(negedge clk);
        checkOutput("rst_c_gnt", 32'(c_gnt), 32'd0);
        checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
        checkOutput("rst_c_rvalid", 32'(c_rvalid), 32'd0);
        checkOutput("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        checkOutput("rst_errs", {30'd0, c_err, d_err}, 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_adr", mem_adr, 32'd0);
        checkOutput("rst_mem_wd", mem_wd, 32'd0);
        checkOutput("rst_c_rd", c_rd, 32'd0);
        checkOutput("rst_d_rd", d_rd, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        setPort(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        setPort(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic idle(int n);
        setPort(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        setPort(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = initVal(i);
            model_mem[i] = initVal(i);
        end
        mg[0] = 1'b0; mg[1] = 1'b0;
        setPort(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        setPort(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        doReset();

        // Single core write, D idle.
        setPort(0, 1'b1, 1'b1, 1'b0, 32'd100, 32'd25);
        applyStimulus();
        checkOutput("t1_c_gnt", 32'(smp_c_gnt), 32'd1);
        checkOutput("t1_mem_we", 32'(smp_mem_we), 32'd1);
        checkOutput("t1_mem_adr", smp_mem_adr, 32'd100);
        checkOutput("t1_mem_wd", smp_mem_wd, 32'd25);
        idle(1);
        checkOutput("t1_c_rvalid", 32'(smp_c_rvalid), 32'd1);
        checkOutput("t1_c_err", 32'(smp_c_err), 32'd0);

        // C then D read word at 96.
        setPort(0, 1'b1, 1'b0, 1'b0, 32'd96, 32'd0);
        applyStimulus();
        checkOutput("t2_c_gnt", 32'(smp_c_gnt), 32'd1);
        setPort(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        setPort(1, 1'b1, 1'b0, 1'b0, 32'd96, 32'd0);
        applyStimulus();
        checkOutput("t2_d_gnt", 32'(smp_d_gnt), 32'd1);
        checkOutput("t2_c_rvalid", {30'd0, smp_c_rvalid, smp_d_rvalid}, 32'd2);
        checkOutput("t2_c_rd", smp_c_rd, 32'd7);
        idle(1);
        checkOutput("t2_d_rvalid", {30'd0, smp_c_rvalid, smp_d_rvalid}, 32'd1);
        checkOutput("t2_d_rd", smp_d_rd, 32'd7);

        // Continuous contention alternates starting with C.
        doReset();
        setPort(0, 1'b1, 1'b0, 1'b0, 32'd8, 32'd0);
        setPort(1, 1'b1, 1'b0, 1'b0, 32'd12, 32'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput("t3_gnt", {30'd0, smp_c_gnt, smp_d_gnt}, (i % 2 == 0) ? 32'd2 : 32'd1);
            if (i > 0)
                checkOutput("t3_rvalid", {30'd0, smp_c_rvalid, smp_d_rvalid},
                            (i % 2 == 1) ? 32'd2 : 32'd1);
        end
        idle(1);

        // D holds a lock: LOCK_MAX grants, then C.
        doReset();
        setPort(1, 1'b1, 1'b0, 1'b1, 32'd16, 32'd0);
        applyStimulus();
        checkOutput("t4_first_d", 32'(smp_d_gnt), 32'd1);
        setPort(0, 1'b1, 1'b0, 1'b0, 32'd20, 32'd0);
        for (int i = 1; i <= LMAX; i++) begin
            applyStimulus();
            checkOutput("t4_gnt", {30'd0, smp_c_gnt, smp_d_gnt}, (i < LMAX) ? 32'd1 : 32'd2);
        end
        idle(1);

        // Saturated lock with C idle keeps D; C then wins immediately.
        doReset();
        setPort(1, 1'b1, 1'b1, 1'b1, 32'd28, 32'h55);
        for (int i = 0; i < LMAX + 3; i++) begin
            applyStimulus();
            checkOutput("t4b_d_gnt", 32'(smp_d_gnt), 32'd1);
        end
        setPort(0, 1'b1, 1'b0, 1'b0, 32'd28, 32'd0);
        applyStimulus();
        checkOutput("t4b_c_gnt", {30'd0, smp_c_gnt, smp_d_gnt}, 32'd2);
        idle(1);

        // Misaligned core write.
        doReset();
        setPort(0, 1'b1, 1'b1, 1'b0, 32'd102, 32'hDEAD);
        applyStimulus();
        checkOutput("t5_c_gnt", 32'(smp_c_gnt), 32'd1);
        checkOutput("t5_mem_we", 32'(smp_mem_we), 32'd0);
        idle(1);
        checkOutput("t5_c_rvalid", 32'(smp_c_rvalid), 32'd1);
        checkOutput("t5_c_err", 32'(smp_c_err), 32'd1);
        checkOutput("t5_c_rd", smp_c_rd, 32'd0);

        // Reset right after a D accept drops its response; tie then goes to C.
        doReset();
        setPort(1, 1'b1, 1'b0, 1'b0, 32'd96, 32'd0);
        applyStimulus();
        checkOutput("t6_d_gnt", 32'(smp_d_gnt), 32'd1);
        doReset();
        idle(1);
        checkOutput("t6_no_rvalid", 32'(smp_d_rvalid), 32'd0);
        setPort(0, 1'b1, 1'b0, 1'b0, 32'd4, 32'd0);
        setPort(1, 1'b1, 1'b0, 1'b0, 32'd8, 32'd0);
        applyStimulus();
        checkOutput("t6_tie", {30'd0, smp_c_gnt, smp_d_gnt}, 32'd2);
        idle(1);

        // Random traffic; requesters hold their request until granted.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_req[p] || mg[p]) begin
                    radr = 32'($urandom_range(0, 63)) << 2;
                    if ($urandom_range(0, 7) == 0) radr[1:0] = 2'($urandom_range(1, 3));
                    setPort(p, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                            $urandom_range(0, 2) == 0, radr, $urandom);
                end
            end
            applyStimulus();
        end
        idle(3);
        checkOutput("queue_drain", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
